// File: rtl/fetch_stage_pkg.sv
// Shared types for the rv32i IF stage: fetch FSM states, IF/ID payload, opcode encodings.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [XLEN-1:0] RESET_PC_C  = 32'h0000_0060;
  localparam logic [XLEN-1:0] NOP_INSTR_C = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DISCARD
  } fetch_state_t;

  typedef enum logic [OPCODE_W-1:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BR     = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_CSR    = 7'b1110011
  } rv32i_opcode_t;

  // IF/ID payload: fetch address and raw instruction word
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry {pc, instr} buffer that parks a fetched instruction while decode is stalled.
module fetch_hold_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic            o_full,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr
);

  logic       r_full;
  fetch_pkt_t r_pkt;

  // Clear wins so a redirect always empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full      <= 1'b0;
      r_pkt.pc    <= '0;
      r_pkt.instr <= NOP_INSTR_C;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full      <= 1'b1;
      r_pkt.pc    <= i_pc;
      r_pkt.instr <= i_instr;
    end
  end

  assign o_full  = r_full;
  assign o_pc    = r_pkt.pc;
  assign o_instr = r_pkt.instr;

endmodule

// File: rtl/fetch_stage.sv
// rv32i IF stage: PC ownership, I-mem read/resp handshake, IF/ID register with stall hold and
// redirect flush. Decoded fields are slices of the registered instruction.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_C,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  input  logic        stall_id,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        valid_id,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic [6:0]  opcode_id,
  output logic [2:0]  funct3_id,
  output logic [6:0]  funct7_id,
  output logic [4:0]  rs1_id,
  output logic [4:0]  rs2_id,
  output logic [4:0]  rd_id
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_stale_addr;
  logic [XLEN-1:0] w_stale_nxt;
  logic [XLEN-1:0] r_inst_addr;
  logic [XLEN-1:0] w_addr_nxt;
  logic            r_inst_read;
  logic            w_read_nxt;

  logic            r_valid_id;
  fetch_pkt_t      r_ifid;
  fetch_pkt_t      w_ifid_pkt;

  logic            w_ifid_load;
  logic            w_ifid_from_hold;
  logic            w_flush;
  logic            w_hold_load;
  logic            w_hold_clear;
  logic            w_hold_full;
  logic [XLEN-1:0] w_hold_pc;
  logic [XLEN-1:0] w_hold_instr;

  logic            w_ifid_free;
  logic [XLEN-1:0] w_pc_inc;
  logic [XLEN-1:0] w_redir_pc;

  assign w_ifid_free = !r_valid_id || !stall_id;
  assign w_pc_inc    = r_pc + XLEN'(4);
  assign w_redir_pc  = redirect_pc & ~XLEN'(3);

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_clear (w_hold_clear),
    .i_pc    (r_pc),
    .i_instr (inst_rdata),
    .o_full  (w_hold_full),
    .o_pc    (w_hold_pc),
    .o_instr (w_hold_instr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_stale_addr <= RESET_PC;
      r_inst_addr  <= RESET_PC;
      r_inst_read  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_stale_addr <= w_stale_nxt;
      r_inst_addr  <= w_addr_nxt;
      r_inst_read  <= w_read_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_stale_nxt      = r_stale_addr;
    w_ifid_load      = 1'b0;
    w_ifid_from_hold = 1'b0;
    w_flush          = 1'b0;
    w_hold_load      = 1'b0;
    w_hold_clear     = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (inst_resp) begin
          w_pc_nxt = w_pc_inc;
          if (w_ifid_free) begin
            w_ifid_load = 1'b1;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!stall_id && w_hold_full) begin
          w_ifid_load      = 1'b1;
          w_ifid_from_hold = 1'b1;
          w_hold_clear     = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end
      S_DISCARD: begin
        if (inst_resp) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Redirect overrides stall and resp; an open request without resp must still complete at its old address
    if (redirect_valid) begin
      w_pc_nxt         = w_redir_pc;
      w_flush          = 1'b1;
      w_ifid_load      = 1'b0;
      w_ifid_from_hold = 1'b0;
      w_hold_load      = 1'b0;
      w_hold_clear     = 1'b1;
      case (r_state)
        S_REQ: begin
          if (inst_resp) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DISCARD;
            w_stale_nxt = r_inst_addr;
          end
        end
        S_DISCARD: w_state_nxt = inst_resp ? S_REQ : S_DISCARD;
        default:   w_state_nxt = S_REQ;
      endcase
    end

    w_read_nxt = (w_state_nxt == S_REQ) || (w_state_nxt == S_DISCARD);
    w_addr_nxt = (w_state_nxt == S_DISCARD) ? w_stale_nxt : w_pc_nxt;
  end

  always_comb begin
    if (w_ifid_from_hold) begin
      w_ifid_pkt.pc    = w_hold_pc;
      w_ifid_pkt.instr = w_hold_instr;
    end else begin
      w_ifid_pkt.pc    = r_pc;
      w_ifid_pkt.instr = inst_rdata;
    end
  end

  // IF/ID register: flush > load > bubble when drained > hold under stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_id   <= 1'b0;
      r_ifid.pc    <= '0;
      r_ifid.instr <= NOP_INSTR;
    end else if (w_flush) begin
      r_valid_id   <= 1'b0;
      r_ifid.instr <= NOP_INSTR;
    end else if (w_ifid_load) begin
      r_valid_id <= 1'b1;
      r_ifid     <= w_ifid_pkt;
    end else if (!stall_id) begin
      r_valid_id   <= 1'b0;
      r_ifid.instr <= NOP_INSTR;
    end
  end

  assign inst_read = r_inst_read;
  assign inst_addr = r_inst_addr;
  assign valid_id  = r_valid_id;
  assign pc_id     = r_ifid.pc;
  assign instr_id  = r_ifid.instr;
  assign opcode_id = r_ifid.instr[6:0];
  assign rd_id     = r_ifid.instr[11:7];
  assign funct3_id = r_ifid.instr[14:12];
  assign rs1_id    = r_ifid.instr[19:15];
  assign rs2_id    = r_ifid.instr[24:20];
  assign funct7_id = r_ifid.instr[31:25];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID deliveries into a queue,
// a monitor pops and compares whenever decode accepts an instruction.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        stall_id;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        valid_id;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic [6:0]  opcode_id;
  logic [2:0]  funct3_id;
  logic [6:0]  funct7_id;
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic [4:0]  rd_id;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] I_A  = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] I_B  = 32'h0020_0113; // addi x2,x0,2
  localparam logic [31:0] I_C  = 32'h0030_8193; // addi x3,x1,3
  localparam logic [31:0] I_D  = 32'h0020_81B3; // add  x3,x1,x2
  localparam logic [31:0] I_E  = 32'h0050_0293; // addi x5,x0,5
  localparam logic [31:0] I_F  = 32'hFFF0_0313; // addi x6,x0,-1
  localparam logic [31:0] I_G  = 32'h0070_0393; // addi x7,x0,7
  localparam logic [31:0] I_H  = 32'h0080_0413; // addi x8,x0,8

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .inst_read      (inst_read),
    .inst_addr      (inst_addr),
    .inst_resp      (inst_resp),
    .inst_rdata     (inst_rdata),
    .stall_id       (stall_id),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .valid_id       (valid_id),
    .pc_id          (pc_id),
    .instr_id       (instr_id),
    .opcode_id      (opcode_id),
    .funct3_id      (funct3_id),
    .funct7_id      (funct7_id),
    .rs1_id         (rs1_id),
    .rs2_id         (rs2_id),
    .rd_id          (rd_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and drop one-cycle pulses
  task automatic cyc();
    @(negedge clk);
    inst_resp      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic resp(input logic [31:0] data);
    inst_resp  = 1'b1;
    inst_rdata = data;
  endtask

  task automatic redir(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
  endtask

  task automatic expect_ifid(input logic [31:0] pc, input logic [31:0] instr);
    exp_q.push_back({pc, instr});
  endtask

  // Monitor: an instruction is consumed when it is valid, not stalled and not flushed this edge
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && valid_id && !stall_id && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_ifid: got pc %h instr %h, expected none", pc_id, instr_id);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc_id", pc_id, e[63:32]);
          chk("sb_instr_id", instr_id, e[31:0]);
          chk("sb_fields", {funct7_id, rs2_id, rs1_id, funct3_id, rd_id, opcode_id}, e[31:0]);
        end
      end
    end
  end

  initial begin
    rst            = 1'b0;
    inst_resp      = 1'b0;
    inst_rdata     = 32'h0;
    stall_id       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rst = 1'b1;
    cyc(); cyc();
    chk("rst_inst_read", 32'(inst_read), 32'd0);
    chk("rst_valid_id", 32'(valid_id), 32'd0);
    chk("rst_pc_id", pc_id, 32'h0);
    chk("rst_instr_id", instr_id, NOP);
    chk("rst_opcode_id", 32'(opcode_id), 32'h13);
    rst = 1'b0;

    // Back-to-back fetch from RESET_PC
    cyc();
    chk("t1_read", 32'(inst_read), 32'd1);
    chk("t1_addr0", inst_addr, 32'h60);
    resp(I_A); expect_ifid(32'h60, I_A);
    cyc();
    chk("t1_addr1", inst_addr, 32'h64);
    chk("t1_valid", 32'(valid_id), 32'd1);
    resp(I_B); expect_ifid(32'h64, I_B);
    cyc();
    chk("t1_addr2", inst_addr, 32'h68);

    // Stall with IF/ID full: resp goes to hold buffer
    stall_id = 1'b1;
    resp(I_C); expect_ifid(32'h68, I_C);
    cyc();
    chk("t2_read_wait", 32'(inst_read), 32'd0);
    chk("t2_pc_id_held", pc_id, 32'h64);
    cyc();
    chk("t2_read_wait2", 32'(inst_read), 32'd0);
    stall_id = 1'b0;
    cyc();
    chk("t2_read_resume", 32'(inst_read), 32'd1);
    chk("t2_addr_resume", inst_addr, 32'h6C);
    chk("t2_pc_id_hold", pc_id, 32'h68);
    cyc();
    chk("t2_bubble_valid", 32'(valid_id), 32'd0);
    chk("t2_bubble_instr", instr_id, NOP);

    // Redirect with open request: old address held until resp, data dropped
    redir(32'h200);
    cyc();
    chk("t3_read", 32'(inst_read), 32'd1);
    chk("t3_addr_stale", inst_addr, 32'h6C);
    cyc();
    chk("t3_addr_stale2", inst_addr, 32'h6C);
    chk("t3_instr_nop", instr_id, NOP);
    resp(32'hDEAD_BEEF);
    cyc();
    chk("t3_addr_target", inst_addr, 32'h200);
    chk("t3_valid", 32'(valid_id), 32'd0);
    resp(I_D);
    cyc();
    chk("t4_opcode", 32'(opcode_id), 32'h33);
    chk("t4_rd_rs1_rs2", {17'h0, rd_id, rs1_id, rs2_id}, {17'h0, 5'd3, 5'd1, 5'd2});
    chk("t4_f3_f7", {22'h0, funct3_id, funct7_id}, 32'h0);

    // Redirect to unaligned target coinciding with resp and stall
    stall_id = 1'b1;
    resp(32'h1234_5678);
    redir(32'h203);
    cyc();
    chk("t4_flush_valid", 32'(valid_id), 32'd0);
    chk("t4_flush_instr", instr_id, NOP);
    chk("t4_addr", inst_addr, 32'h200);
    chk("t4_read", 32'(inst_read), 32'd1);
    stall_id = 1'b0;
    resp(I_E);
    cyc();
    chk("t5_pc_id", pc_id, 32'h200);
    chk("t5_instr_id", instr_id, I_E);
    stall_id = 1'b1;
    resp(I_F);
    cyc();
    chk("t5_read_wait", 32'(inst_read), 32'd0);
    redir(32'h300);
    cyc();
    chk("t5_read", 32'(inst_read), 32'd1);
    chk("t5_addr", inst_addr, 32'h300);
    chk("t5_valid", 32'(valid_id), 32'd0);
    stall_id = 1'b0;
    cyc();
    chk("t5_no_stale_valid", 32'(valid_id), 32'd0);
    resp(I_G); expect_ifid(32'h300, I_G);
    cyc();
    chk("t5_addr_next", inst_addr, 32'h304);

    // Async reset while discarding
    cyc();
    redir(32'h400);
    cyc();
    chk("t6_discard_read", 32'(inst_read), 32'd1);
    chk("t6_discard_addr", inst_addr, 32'h304);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_read", 32'(inst_read), 32'd0);
    chk("t6_rst_valid", 32'(valid_id), 32'd0);
    chk("t6_rst_pc_id", pc_id, 32'h0);
    chk("t6_rst_instr", instr_id, NOP);
    cyc();
    rst = 1'b0;
    chk("t6_idle_gap", 32'(inst_read), 32'd0);
    cyc();
    chk("t6_restart_read", 32'(inst_read), 32'd1);
    chk("t6_restart_addr", inst_addr, 32'h60);

    // PC wrap at top of address space; redirect bits [1:0] forced low
    resp(I_H);
    redir(32'hFFFF_FFFF);
    cyc();
    chk("wrap_addr_top", inst_addr, 32'hFFFF_FFFC);
    chk("wrap_valid", 32'(valid_id), 32'd0);
    resp(I_A); expect_ifid(32'hFFFF_FFFC, I_A);
    cyc();
    chk("wrap_addr_zero", inst_addr, 32'h0);
    cyc();
    cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
